// File: rtl/string_detector_ctrl_if.sv
// string_detector_ctrl_if: session control, serial bit handshake and result bundle
interface string_detector_ctrl_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int LEN_W = 8
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] frame_len;
    logic             mode;
    logic             bit_in;
    logic             bit_valid;
    logic             bit_ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] N;
    logic             overflow;
    modport master (
        output start, pattern, frame_len, mode, bit_in, bit_valid,
        input  bit_ready, busy, done, N, overflow
    );
    modport slave (
        input  start, pattern, frame_len, mode, bit_in, bit_valid,
        output bit_ready, busy, done, N, overflow
    );
endinterface

// File: rtl/string_detector_ctrl.sv
// string_detector_ctrl: framed serial pattern counter with overlapping/non-overlapping modes
module string_detector_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int LEN_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    string_detector_ctrl_if.slave bus
);
    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] win_q, win_d, pat_q, pat_d, win_nx;
    logic [FW-1:0]    fill_q, fill_d, fill_nx;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic             mode_q, mode_d, ovf_q, ovf_d, match;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        fill_d  = fill_q;
        rem_d   = rem_q;
        pat_d   = pat_q;
        mode_d  = mode_q;
        n_d     = n_q;
        ovf_d   = ovf_q;
        win_nx  = {win_q[PAT_W-2:0], bus.bit_in};
        fill_nx = fill_q == FULL ? FULL : fill_q + 1'b1;
        match   = fill_nx == FULL && win_nx == pat_q;
        if (state_q == IDLE && bus.start) begin
            n_d   = '0;
            ovf_d = 1'b0;
            if (bus.frame_len != '0) begin
                pat_d   = bus.pattern;
                mode_d  = bus.mode;
                rem_d   = bus.frame_len;
                win_d   = '0;
                fill_d  = '0;
                state_d = RUN;
            end else begin
                state_d = REPORT;
            end
        end else if (state_q == RUN && bus.bit_valid) begin
            win_d   = win_nx;
            fill_d  = match && mode_q ? '0 : fill_nx;
            rem_d   = rem_q - 1'b1;
            n_d     = match && n_q != '1 ? n_q + 1'b1 : n_q;
            ovf_d   = ovf_q | (match && n_q == '1);
            state_d = rem_q == LEN_W'(1) ? REPORT : RUN;
        end else if (state_q == REPORT) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= '0;
            fill_q  <= '0;
            rem_q   <= '0;
            pat_q   <= '0;
            mode_q  <= 1'b0;
            n_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            rem_q   <= rem_d;
            pat_q   <= pat_d;
            mode_q  <= mode_d;
            n_q     <= n_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.bit_ready = state_q == RUN;
    assign bus.busy      = state_q != IDLE;
    assign bus.done      = state_q == REPORT;
    assign bus.N         = n_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_string_detector_ctrl.sv
// tb_string_detector_ctrl: directed sessions with hand-computed counts
module tb_string_detector_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    string_detector_ctrl_if #(.PAT_W(4), .CNT_W(4), .LEN_W(8)) bus ();

    string_detector_ctrl #(.PAT_W(4), .CNT_W(4), .LEN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [31:0] STREAM1 = 32'h000661B1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string tag, input logic [3:0] pat, input logic md,
                             input logic [7:0] len, input logic [31:0] bits, input bit gaps,
                             input int exp_n, input bit exp_ovf);
        int g;
        bus.pattern   = pat;
        bus.mode      = md;
        bus.frame_len = len;
        bus.start     = 1'b1;
        tick;
        bus.start     = 1'b0;
        bus.pattern   = ~pat;
        bus.mode      = ~md;
        bus.frame_len = 8'd1;
        chk({tag, " n_clr"}, bus.N, 0);
        chk({tag, " ovf_clr"}, bus.overflow, 0);
        chk({tag, " busy_run"}, bus.busy, 1);
        for (int i = 0; i < int'(len); i++) begin
            if (gaps) begin
                g = $urandom_range(1, 5);
                bus.bit_valid = 1'b0;
                bus.bit_in    = 1'b1;
                repeat (g) begin
                    tick;
                    chk({tag, " rdy_gap"}, bus.bit_ready, 1);
                end
            end
            bus.bit_in    = bits[int'(len) - 1 - i];
            bus.bit_valid = 1'b1;
            chk({tag, " rdy"}, bus.bit_ready, 1);
            chk({tag, " done_early"}, bus.done, 0);
            tick;
        end
        bus.bit_valid = 1'b0;
        chk({tag, " done"}, bus.done, 1);
        chk({tag, " n"}, bus.N, exp_n);
        chk({tag, " ovf"}, bus.overflow, exp_ovf);
        chk({tag, " busy_rep"}, bus.busy, 1);
        chk({tag, " rdy_rep"}, bus.bit_ready, 0);
        tick;
        chk({tag, " done_off"}, bus.done, 0);
        chk({tag, " busy_off"}, bus.busy, 0);
        chk({tag, " n_hold"}, bus.N, exp_n);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.pattern   = '0;
        bus.frame_len = '0;
        bus.mode      = 1'b0;
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        #2;
        chk("rst busy", bus.busy, 0);
        chk("rst rdy", bus.bit_ready, 0);
        chk("rst done", bus.done, 0);
        chk("rst n", bus.N, 0);
        chk("rst ovf", bus.overflow, 0);
        #10 rst = 1'b0;
        tick;

        run_frame("t1", 4'b0110, 1'b0, 8'd20, STREAM1, 1'b0, 4, 1'b0);
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b0;
        repeat (4) tick;
        chk("idle bits n", bus.N, 4);
        chk("idle bits busy", bus.busy, 0);
        bus.bit_valid = 1'b0;

        run_frame("t2", 4'b0110, 1'b1, 8'd20, STREAM1, 1'b0, 3, 1'b0);
        run_frame("t3m0", 4'b1111, 1'b0, 8'd7, 32'h7F, 1'b0, 4, 1'b0);
        run_frame("t3m1", 4'b1111, 1'b1, 8'd7, 32'h7F, 1'b0, 1, 1'b0);
        run_frame("t4", 4'b0000, 1'b0, 8'd20, 32'h0, 1'b0, 15, 1'b1);
        run_frame("t5", 4'b0110, 1'b0, 8'd20, STREAM1, 1'b1, 4, 1'b0);
        run_frame("short", 4'b0110, 1'b0, 8'd3, 32'h3, 1'b0, 0, 1'b0);

        bus.pattern   = 4'b0110;
        bus.mode      = 1'b0;
        bus.frame_len = 8'd20;
        bus.start     = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.bit_in    = STREAM1[19 - i];
            bus.bit_valid = 1'b1;
            tick;
        end
        chk("t6 n_pre", bus.N, 2);
        rst = 1'b1;
        #1;
        chk("t6 busy", bus.busy, 0);
        chk("t6 rdy", bus.bit_ready, 0);
        chk("t6 n", bus.N, 0);
        chk("t6 done", bus.done, 0);
        #2 rst = 1'b0;
        repeat (3) begin
            tick;
            chk("t6 no_done", bus.done, 0);
        end
        bus.bit_valid = 1'b0;

        bus.frame_len = 8'd0;
        bus.start     = 1'b1;
        tick;
        bus.frame_len = 8'd5;
        chk("z done", bus.done, 1);
        chk("z n", bus.N, 0);
        chk("z rdy", bus.bit_ready, 0);
        tick;
        bus.start = 1'b0;
        chk("z start_ignored", bus.busy, 0);
        chk("z done_off", bus.done, 0);

        run_frame("t6b", 4'b0110, 1'b0, 8'd3, 32'h6, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/string_detector_ctrl.md
Name: string_detector_ctrl

Overview:
- Sequences a serial pattern-detection session over a framed bit stream.
- Per session: accepts a start request with pattern, frame length and counting mode, then accepts exactly frame_len bits through a valid/ready handshake.
- Counts pattern occurrences with a built-in PAT_W-bit shift-window matcher, then reports the final count with a one-cycle done pulse.
- Sits between the bit source and downstream consumers of the count N. Mode 0 (overlapping) matches the existing detector's counting semantics.

Parameters:
PAT_W, 4, pattern width in bits (>=2)
CNT_W, 4, match counter width
LEN_W, 8, frame length counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  session request, sampled only in IDLE
pattern  input  PAT_W  pattern to detect; latched on accepted start; MSB = oldest bit
frame_len  input  LEN_W  number of bits in the session; latched on accepted start
mode  input  1  0 = overlapping count, 1 = non-overlapping count; latched on accepted start
bit_in  input  1  serial data bit
bit_valid  input  1  bit_in valid
bit_ready  output  1  controller accepts a bit this cycle
busy  output  1  session in progress (RUN or REPORT)
done  output  1  one-cycle pulse; N final
N  output  CNT_W  match count; holds until the next accepted start
overflow  output  1  sticky: count saturated this session

Behaviour:
Reset (async, rst=1):
- state=IDLE; all outputs 0.
- Shift window, fill counter, remaining counter and latched config all cleared.
- Applies immediately, including mid-session. No partial result is kept.

States: IDLE, RUN, REPORT.

IDLE:
- bit_ready=0, busy=0.
- start=1 and frame_len!=0 -> latch pattern, frame_len, mode; clear window, fill, N, overflow -> RUN.
- start=1 and frame_len==0 -> clear N, overflow -> REPORT.
- start=0 -> stay in IDLE; N and overflow hold.

RUN:
- bit_ready=1, busy=1. A bit is accepted on a clock edge with bit_valid=1.
- On accept:
  - win_next = {win[PAT_W-2:0], bit_in}, i.e. new bit enters at the LSB.
  - fill_next = min(fill+1, PAT_W).
  - remaining decrements.
- match = (fill_next==PAT_W) && (win_next==pattern_latched).
- On match:
  - If N == 2^CNT_W-1: N holds and overflow is set to 1.
  - Otherwise N increments.
- Mode 1 only: a match also forces fill to 0, so the next match needs PAT_W fresh bits. Mode 0 keeps fill=PAT_W.
- N is registered; it reflects an accepted bit in the cycle after the accepting edge.
- Accepting the last bit (remaining==1) -> REPORT on the same edge. N is updated on that edge too.
- bit_valid=0 -> no state change. Gaps of any length are allowed.
- start is ignored while in RUN.

REPORT:
- Lasts exactly one cycle. done=1, busy=1, bit_ready=0 -> IDLE.
- done is high in the cycle immediately after the edge that accepted the last bit; N is final in that cycle.

Other rules:
- Bits presented outside RUN are not accepted (bit_ready=0) and have no effect.
- A start asserted in the same cycle as done is ignored, because the FSM is in REPORT. A new start is accepted from the following IDLE cycle.
- Frames shorter than PAT_W complete normally with N=0.
- Pattern, mode and frame_len changes after start do not affect the running session.

Test Plan:
1. pattern=0110, mode=0, frame_len=20, bit_valid continuous, stream 0,1,1,0,0,1,1,0,0,0,0,1,1,0,1,1,0,0,0,1 -> N=4, overflow=0, done one cycle after bit 20 accepted, busy low the cycle after done.
2. Same stream and pattern, mode=1 -> N=3; the window at bits 13..16 is suppressed because it overlaps the match at bits 10..13.
3. pattern=1111, frame_len=7, seven 1s -> mode 0: N=4; mode 1: N=1.
4. pattern=0000, mode=0, frame_len=20, all zeros (17 overlapping windows) -> N=15, overflow=1 at done; next start clears N to 0 and overflow to 0 in the cycle after start.
5. Repeat test 1 with bit_valid deasserted for random 1-5 cycle gaps -> identical N=4; done exactly one cycle after the 20th accepted bit; bit_ready stays high throughout RUN.
6. Mid-RUN rst pulse after 10 bits -> same cycle: busy=0, bit_ready=0, N=0, done never pulses. Then start with frame_len=0 -> done pulses in the cycle after start, N=0. Then start with frame_len=3 -> N=0 at done.
